// File: rtl/dmem_access_unit.sv
// Load/store unit in front of a 32-bit word memory without byte enables.
// Sub-word stores are read-modify-write; sub-word loads are extracted and extended.
module dmem_access_unit #(
    parameter int MEM_ADDR_W  = 16,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  resp_valid_o,
    output logic                  resp_err_o,
    output logic [31:0]           resp_rdata_o,
    output logic [MEM_ADDR_W-1:0] mem_address_o,
    output logic [31:0]           mem_data_o,
    output logic                  mem_wren_o,
    input  logic [31:0]           mem_q_i
);
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ISSUE       = 3'd1;
    localparam logic [2:0] S_READ_WAIT   = 3'd2;
    localparam logic [2:0] S_MERGE_WRITE = 3'd3;
    localparam logic [2:0] S_RESP        = 3'd4;
    localparam logic [2:0] S_ERR         = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [1:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic                  uns_q, uns_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           rdata_q, rdata_d;

    logic        accept, req_err, range_err, word_store;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val, merged;

    assign accept     = req_valid_i && (state_q == S_IDLE);
    assign range_err  = CHECK_RANGE && ((req_addr_i >> (MEM_ADDR_W + 2)) != 32'd0);
    assign req_err    = (req_size_i == 2'b11)
                      || ((req_size_i == 2'b01) && req_addr_i[0])
                      || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00))
                      || range_err;
    assign word_store = write_q && (size_q == 2'b10);

    always_comb begin
        byte_sel = mem_q_i[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_q_i[31:16] : mem_q_i[15:0];
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_val = mem_q_i;
        endcase
        // data_q still holds the right-aligned store data until the merge lands
        merged = mem_q_i;
        if (size_q == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        else if (lane_q[1])
            merged[31:16] = data_q[15:0];
        else
            merged[15:0] = data_q[15:0];
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lane_d  = req_addr_i[1:0];
                    size_d  = req_size_i;
                    write_d = req_write_i;
                    uns_d   = req_unsigned_i;
                    if (req_err) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ISSUE;
                        addr_d  = req_addr_i[MEM_ADDR_W+1:2];
                        data_d  = req_wdata_i;
                    end
                end
            end
            S_ISSUE:       state_d = word_store ? S_RESP : S_READ_WAIT;
            S_READ_WAIT: begin
                if (write_q) begin
                    data_d  = merged;
                    state_d = S_MERGE_WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = S_RESP;
                end
            end
            S_MERGE_WRITE: state_d = S_RESP;
            default:       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    // Write enable decodes from state so reset kills it without waiting for an edge
    assign req_ready_o   = (state_q == S_IDLE);
    assign mem_wren_o    = ((state_q == S_ISSUE) && word_store) || (state_q == S_MERGE_WRITE);
    assign resp_valid_o  = (state_q == S_RESP) || (state_q == S_ERR);
    assign resp_err_o    = (state_q == S_ERR);
    assign mem_address_o = addr_q;
    assign mem_data_o    = data_q;
    assign resp_rdata_o  = rdata_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit with a 1-cycle-latency word memory model.
`timescale 1ps/1ps
module tb_dmem_access_unit;
    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid_i = 1'b0, req_write_i = 1'b0, req_unsigned_i = 1'b0;
    logic [1:0]    req_size_i = 2'b00;
    logic [31:0]   req_addr_i = '0, req_wdata_i = '0;
    logic          req_ready_o, resp_valid_o, resp_err_o, mem_wren_o;
    logic [31:0]   resp_rdata_o, mem_data_o, mem_q;
    logic [AW-1:0] mem_address_o;

    always #5000 clock = ~clock;

    dmem_access_unit #(.MEM_ADDR_W(AW), .CHECK_RANGE(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o),
        .resp_rdata_o(resp_rdata_o), .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
        .mem_wren_o(mem_wren_o), .mem_q_i(mem_q)
    );

    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (mem_wren_o) mem[mem_address_o] <= mem_data_o;
        mem_q <= mem[mem_address_o];
    end

    typedef struct {
        string       tag;
        logic        err;
        logic        is_ld;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_err = 0;
    int          ncyc = 0, wr_cnt = 0, last_acc = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        ncyc++;
        if (mem_wren_o) begin
            wr_cnt++;
            wr_addr = 32'(mem_address_o);
            wr_data = mem_data_o;
        end
        if (resp_valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_err"}, 32'(resp_err_o), 32'(e.err));
                chk({e.tag, "_lat"}, 32'(ncyc - e.acc), 32'(e.lat));
                if (e.is_ld) chk({e.tag, "_data"}, resp_rdata_o, e.rdata);
            end
        end
    endtask

    always @(negedge clock) if (!reset) mon();

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic err, input logic [31:0] rd, input bit hold);
        exp_t e;
        int   n;
        @(negedge clock);
        req_valid_i = 1'b1; req_write_i = wr; req_size_i = sz;
        req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wd;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready_o) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
        @(posedge clock);
        e.tag = tag; e.err = err; e.is_ld = !wr && !err; e.rdata = rd;
        e.lat = err ? 1 : (wr ? ((sz == 2'b10) ? 2 : 4) : 3);
        e.acc = ncyc;
        last_acc = ncyc;
        sb.push_back(e);
        #1;
        if (!hold) req_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) chk({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          wc;
        int          accs[16];
        logic [31:0] m0, m4;

        #1000;
        chk("rst_wren", 32'(mem_wren_o), 32'd0);
        chk("rst_addr", 32'(mem_address_o), 32'd0);
        chk("rst_data", mem_data_o, 32'd0);
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_err", 32'(resp_err_o), 32'd0);
        chk("rst_rdata", resp_rdata_o, 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // 1: word store then word load
        wc = wr_cnt;
        do_req("sw10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        drain("sw10");
        chk("sw10_wrcnt", 32'(wr_cnt - wc), 32'd1);
        chk("sw10_wraddr", wr_addr, 32'd4);
        chk("sw10_wrdata", wr_data, 32'hDEADBEEF);
        do_req("lw10", 0, 2'b10, 0, 32'h10, 0, 0, 32'hDEADBEEF, 0);
        drain("lw10");

        // 2: byte read-modify-write and byte loads
        do_req("sw10b", 1, 2'b10, 0, 32'h10, 32'h11223344, 0, 0, 0);
        drain("sw10b");
        wc = wr_cnt;
        do_req("sb11", 1, 2'b00, 0, 32'h11, 32'h000000AB, 0, 0, 0);
        drain("sb11");
        chk("sb11_wrcnt", 32'(wr_cnt - wc), 32'd1);
        chk("sb11_wrdata", wr_data, 32'h1122AB44);
        chk("sb11_mem", mem[4], 32'h1122AB44);
        do_req("lb11", 0, 2'b00, 0, 32'h11, 0, 0, 32'hFFFFFFAB, 0);
        do_req("lbu11", 0, 2'b00, 1, 32'h11, 0, 0, 32'h000000AB, 0);
        drain("lb11");

        // 3: halfwords
        do_req("lh12a", 0, 2'b01, 0, 32'h12, 0, 0, 32'h00001122, 0);
        drain("lh12a");
        do_req("sh12", 1, 2'b01, 0, 32'h12, 32'h00008001, 0, 0, 0);
        drain("sh12");
        chk("sh12_mem", mem[4], 32'h8001AB44);
        do_req("lh12b", 0, 2'b01, 0, 32'h12, 0, 0, 32'hFFFF8001, 0);
        do_req("lhu12", 0, 2'b01, 1, 32'h12, 0, 0, 32'h00008001, 0);
        do_req("lhu10", 0, 2'b01, 1, 32'h10, 0, 0, 32'h0000AB44, 0);
        drain("lh12b");

        // 4: error requests touch nothing
        m0 = mem[0]; m4 = mem[4]; wc = wr_cnt;
        do_req("e_lh13", 0, 2'b01, 0, 32'h13, 0, 1, 0, 0);
        do_req("e_sw02", 1, 2'b10, 0, 32'h02, 32'h12345678, 1, 0, 0);
        do_req("e_sz11", 1, 2'b11, 0, 32'h10, 32'h0BADF00D, 1, 0, 0);
        do_req("e_range", 0, 2'b10, 0, 32'h00040000, 0, 1, 0, 0);
        drain("err");
        chk("err_wrcnt", 32'(wr_cnt - wc), 32'd0);
        chk("err_mem0", mem[0], m0);
        chk("err_mem4", mem[4], m4);
        chk("err_rdata_hold", resp_rdata_o, 32'h0000AB44);

        // 5: reset in the merge-write cycle of a byte store
        do_req("sw20", 1, 2'b10, 0, 32'h20, 32'h55667788, 0, 0, 0);
        drain("sw20");
        wc = wr_cnt;
        @(negedge clock);
        chk("t5_ready", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'b00;
        req_addr_i = 32'h21; req_wdata_i = 32'h000000CC;
        @(posedge clock);
        #1 req_valid_i = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 chk("t5_wren_before", 32'(mem_wren_o), 32'd1);
        #1 reset = 1'b1;
        #1 chk("t5_wren_drop", 32'(mem_wren_o), 32'd0);
        chk("t5_valid_rst", 32'(resp_valid_o), 32'd0);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'b10;
        req_addr_i = 32'h20; req_wdata_i = 32'hFFFFFFFF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        req_valid_i = 1'b0;
        #100 reset = 1'b0;
        chk("t5_ready_after", 32'(req_ready_o), 32'd1);
        repeat (3) @(negedge clock);
        chk("t5_mem", mem[8], 32'h55667788);
        chk("t5_wrcnt", 32'(wr_cnt - wc), 32'd0);

        // 6: valid held high across back-to-back stores then loads
        for (int i = 0; i < 16; i++) begin
            do_req("b2b_sw", 1, 2'b10, 0, 32'(4 * i), 32'(i), 0, 0, 1);
            accs[i] = last_acc;
        end
        for (int i = 1; i < 16; i++) chk("b2b_sw_gap", 32'(accs[i] - accs[i-1]), 32'd3);
        for (int i = 0; i < 16; i++) begin
            do_req("b2b_lw", 0, 2'b10, 0, 32'(4 * i), 0, 0, 32'(i), 1);
            accs[i] = last_acc;
        end
        req_valid_i = 1'b0;
        for (int i = 1; i < 16; i++) chk("b2b_lw_gap", 32'(accs[i] - accs[i-1]), 32'd4);
        drain("b2b");
        repeat (2) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
